cpu_store_checker: RTL and testbench

// Synthesizable, parametrised self-check block for multi-cycle CPU benches and FPGA bring-up.

---
 rtl/cpu_store_checker_if.sv | 32 +++
 rtl/cpu_store_checker.sv | 130 +++++++++++++
 tb/tb_cpu_store_checker.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/cpu_store_checker_if.sv
// cpu_store_checker_if: table-load, control, CPU store snoop and result signals of the store checker
interface cpu_store_checker_if #(
  parameter int W     = 32,
  parameter int IDX_W = 3
);
  logic             exp_we;
  logic [IDX_W-1:0] exp_idx;
  logic [W-1:0]     exp_addr;
  logic [W-1:0]     exp_data;
  logic [IDX_W:0]   n_exp;
  logic             start;
  logic             memwrite;
  logic [W-1:0]     dataaddr;
  logic [W-1:0]     writedata;
  logic [W-1:0]     pc;
  logic             busy;
  logic             pass;
  logic             fail;
  logic [1:0]       fail_code;
  logic [IDX_W-1:0] fail_idx;
  logic [W-1:0]     fail_pc;
  logic [IDX_W:0]   match_cnt;
  logic [31:0]      cycles;
  modport master (
    output exp_we, exp_idx, exp_addr, exp_data, n_exp, start, memwrite, dataaddr, writedata, pc,
    input  busy, pass, fail, fail_code, fail_idx, fail_pc, match_cnt, cycles
  );
  modport slave (
    input  exp_we, exp_idx, exp_addr, exp_data, n_exp, start, memwrite, dataaddr, writedata, pc,
    output busy, pass, fail, fail_code, fail_idx, fail_pc, match_cnt, cycles
  );
endinterface

// File: rtl/cpu_store_checker.sv
// cpu_store_checker: compares snooped CPU stores against a loaded table of expected (addr,data) pairs
module cpu_store_checker #(
  parameter int W       = 32,
  parameter int DEPTH   = 8,
  parameter int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int TIMEOUT = 1000,
  parameter int ORDERED = 1
) (
  input logic                clk,
  input logic                reset,
  cpu_store_checker_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;
  localparam logic [IDX_W:0] DEPTH_N = (IDX_W+1)'(DEPTH);
  state_t           state_q, state_d;
  logic [IDX_W:0]   n_q, n_d, match_cnt_q, match_cnt_d;
  logic [31:0]      cycles_q, cycles_d;
  logic [DEPTH-1:0] flag_q, flag_d;
  logic             pass_q, pass_d, fail_q, fail_d;
  logic [1:0]       code_q, code_d;
  logic [IDX_W-1:0] fidx_q, fidx_d;
  logic [W-1:0]     fpc_q, fpc_d;
  logic [W-1:0]     tbl_addr [DEPTH];
  logic [W-1:0]     tbl_data [DEPTH];
  logic             tbl_we, store, hit, mis, done;
  logic [DEPTH-1:0] addr_eq, full_eq;
  logic [IDX_W-1:0] cur, hit_idx;
  logic [IDX_W:0]   n_in;
  assign cur  = match_cnt_q[IDX_W-1:0];
  assign n_in = (bus.n_exp > DEPTH_N) ? DEPTH_N : bus.n_exp;
  assign tbl_we = bus.exp_we && state_q != RUN && 32'(bus.exp_idx) < DEPTH;
  assign store = state_q == RUN && bus.memwrite;
  // Unordered mode only considers entries below n that have not matched yet
  always_comb begin
    addr_eq = '0;
    full_eq = '0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      addr_eq[i] = i < 32'(n_q) && !flag_q[i] && tbl_addr[i] == bus.dataaddr;
      full_eq[i] = addr_eq[i] && tbl_data[i] == bus.writedata;
    end
    for (int i = DEPTH-1; i >= 0; i--)
      if (full_eq[i]) hit_idx = IDX_W'(i);
  end
  assign hit  = (ORDERED != 0) ? (tbl_addr[cur] == bus.dataaddr && tbl_data[cur] == bus.writedata)
                               : |full_eq;
  assign mis  = (ORDERED != 0) ? !hit : (!hit && |addr_eq);
  assign done = store && hit && (match_cnt_q + 1'b1) == n_q;
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    match_cnt_d = match_cnt_q;
    cycles_d    = cycles_q;
    flag_d      = flag_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    code_d      = code_q;
    fidx_d      = fidx_q;
    fpc_d       = fpc_q;
    if (state_q != RUN && bus.start) begin
      state_d     = RUN;
      n_d         = n_in;
      match_cnt_d = '0;
      cycles_d    = '0;
      flag_d      = '0;
      pass_d      = 1'b0;
      fail_d      = 1'b0;
      code_d      = 2'd0;
      fidx_d      = '0;
      fpc_d       = '0;
    end else if (state_q == RUN) begin
      cycles_d = &cycles_q ? cycles_q : cycles_q + 1'b1;
      if (store && hit) begin
        match_cnt_d = match_cnt_q + 1'b1;
        flag_d[(ORDERED != 0) ? cur : hit_idx] = 1'b1;
      end
      // Completing match wins over mismatch, which wins over timeout
      if (n_q == '0 || done) begin
        state_d = PASS;
        pass_d  = 1'b1;
      end else if ((store && mis) || cycles_q == 32'(TIMEOUT-1)) begin
        state_d = FAIL;
        fail_d  = 1'b1;
        code_d  = (store && mis) ? 2'd1 : 2'd2;
        fidx_d  = (ORDERED != 0) ? cur : '0;
        fpc_d   = bus.pc;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      n_q         <= '0;
      match_cnt_q <= '0;
      cycles_q    <= '0;
      flag_q      <= '0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      code_q      <= 2'd0;
      fidx_q      <= '0;
      fpc_q       <= '0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      match_cnt_q <= match_cnt_d;
      cycles_q    <= cycles_d;
      flag_q      <= flag_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      code_q      <= code_d;
      fidx_q      <= fidx_d;
      fpc_q       <= fpc_d;
    end
  end
  // Table storage is deliberately left out of reset; it is reloaded before each run
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      tbl_addr[bus.exp_idx] <= bus.exp_addr;
      tbl_data[bus.exp_idx] <= bus.exp_data;
    end
  end
  assign bus.busy      = state_q == RUN;
  assign bus.pass      = pass_q;
  assign bus.fail      = fail_q;
  assign bus.fail_code = code_q;
  assign bus.fail_idx  = fidx_q;
  assign bus.fail_pc   = fpc_q;
  assign bus.match_cnt = match_cnt_q;
  assign bus.cycles    = cycles_q;
endmodule

// File: tb/tb_cpu_store_checker.sv
// tb_cpu_store_checker: scoreboard bench for ordered and unordered store checkers
module tb_cpu_store_checker;
  logic clk = 0, reset = 0;
  always #5 clk = ~clk;
  logic        exp_we = 0, start_o = 0, start_u = 0, memwrite = 0;
  logic [2:0]  exp_idx = 0;
  logic [31:0] exp_addr = 0, exp_data = 0, dataaddr = 0, writedata = 0, pc = 0;
  logic [3:0]  n_exp = 0;
  int checks = 0, errors = 0;
  cpu_store_checker_if #(.W(32), .IDX_W(3)) bo ();
  cpu_store_checker_if #(.W(32), .IDX_W(3)) bu ();
  assign bo.exp_we = exp_we;     assign bu.exp_we = exp_we;
  assign bo.exp_idx = exp_idx;   assign bu.exp_idx = exp_idx;
  assign bo.exp_addr = exp_addr; assign bu.exp_addr = exp_addr;
  assign bo.exp_data = exp_data; assign bu.exp_data = exp_data;
  assign bo.n_exp = n_exp;       assign bu.n_exp = n_exp;
  assign bo.start = start_o;     assign bu.start = start_u;
  assign bo.memwrite = memwrite; assign bu.memwrite = memwrite;
  assign bo.dataaddr = dataaddr; assign bu.dataaddr = dataaddr;
  assign bo.writedata = writedata; assign bu.writedata = writedata;
  assign bo.pc = pc;             assign bu.pc = pc;
  cpu_store_checker #(.W(32), .DEPTH(8), .TIMEOUT(50), .ORDERED(1)) u_ord (.clk(clk), .reset(reset), .bus(bo));
  cpu_store_checker #(.W(32), .DEPTH(8), .TIMEOUT(50), .ORDERED(0)) u_unord (.clk(clk), .reset(reset), .bus(bu));
  typedef struct {
    logic p; logic f; logic [1:0] code; logic [2:0] idx; logic [31:0] pc; logic [3:0] mc; logic [31:0] cyc;
  } exp_t;
  exp_t q_o[$], q_u[$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic expect_res(input bit u, input logic p, input logic f, input logic [1:0] code,
                            input logic [2:0] idx, input logic [31:0] epc, input logic [3:0] mc, input logic [31:0] cyc);
    exp_t e;
    e = '{p, f, code, idx, epc, mc, cyc};
    if (u) q_u.push_back(e); else q_o.push_back(e);
  endtask
  task automatic cmp(input string t, input exp_t e, input logic busy, input logic p, input logic f,
                     input logic [1:0] code, input logic [2:0] idx, input logic [31:0] fpc,
                     input logic [3:0] mc, input logic [31:0] cyc);
    chk({t, ".busy"}, 32'(busy), 0);
    chk({t, ".pass"}, 32'(p), 32'(e.p));
    chk({t, ".fail"}, 32'(f), 32'(e.f));
    chk({t, ".fail_code"}, 32'(code), 32'(e.code));
    chk({t, ".fail_idx"}, 32'(idx), 32'(e.idx));
    chk({t, ".fail_pc"}, fpc, e.pc);
    chk({t, ".match_cnt"}, 32'(mc), 32'(e.mc));
    chk({t, ".cycles"}, cyc, e.cyc);
  endtask
  // Monitor: every new pass/fail assertion consumes one scoreboard entry
  logic prev_o = 0, prev_u = 0;
  always @(negedge clk) begin
    if (reset) begin
      if ((bo.pass | bo.fail) && !prev_o) begin
        if (q_o.size() == 0) begin
          checks++; errors++;
          $display("FAIL ord_unexpected: got pass=%0b fail=%0b expected no result", bo.pass, bo.fail);
        end else
          cmp("ord", q_o.pop_front(), bo.busy, bo.pass, bo.fail, bo.fail_code, bo.fail_idx, bo.fail_pc, bo.match_cnt, bo.cycles);
      end
      if ((bu.pass | bu.fail) && !prev_u) begin
        if (q_u.size() == 0) begin
          checks++; errors++;
          $display("FAIL unord_unexpected: got pass=%0b fail=%0b expected no result", bu.pass, bu.fail);
        end else
          cmp("unord", q_u.pop_front(), bu.busy, bu.pass, bu.fail, bu.fail_code, bu.fail_idx, bu.fail_pc, bu.match_cnt, bu.cycles);
      end
    end
    prev_o <= reset && (bo.pass | bo.fail);
    prev_u <= reset && (bu.pass | bu.fail);
  end
  task automatic tick(); @(posedge clk); #1; endtask
  task automatic wr(input logic [2:0] i, input logic [31:0] a, input logic [31:0] d);
    exp_we = 1; exp_idx = i; exp_addr = a; exp_data = d; tick(); exp_we = 0;
  endtask
  task automatic go(input bit u, input logic [3:0] n);
    n_exp = n; if (u) start_u = 1; else start_o = 1; tick(); start_o = 0; start_u = 0;
  endtask
  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
    memwrite = 1; dataaddr = a; writedata = d; pc = p; tick(); memwrite = 0;
  endtask
  task automatic chk_reset_vals(input string t);
    chk({t, ".busy"}, 32'(bo.busy), 0);
    chk({t, ".pass"}, 32'(bo.pass), 0);
    chk({t, ".fail"}, 32'(bo.fail), 0);
    chk({t, ".fail_code"}, 32'(bo.fail_code), 0);
    chk({t, ".fail_idx"}, 32'(bo.fail_idx), 0);
    chk({t, ".fail_pc"}, bo.fail_pc, 0);
    chk({t, ".match_cnt"}, 32'(bo.match_cnt), 0);
    chk({t, ".cycles"}, bo.cycles, 0);
  endtask
  initial begin
    repeat (2) tick();
    chk_reset_vals("reset");
    chk("reset.unord_busy", 32'(bu.busy), 0);
    chk("reset.unord_pass", 32'(bu.pass | bu.fail), 0);
    reset = 1; tick();
    // T1: single ordered entry matched in RUN cycle 20
    wr(0, 6, 6); go(0, 1); repeat (20) tick();
    expect_res(0, 1, 0, 0, 0, 0, 1, 21);
    st(6, 6, 32'h100); tick();
    // T2: out-of-order store in ordered mode
    wr(0, 4, 1); wr(1, 8, 2); go(0, 2); repeat (3) tick();
    expect_res(0, 0, 1, 1, 0, 32'h200, 0, 4);
    st(8, 2, 32'h200); tick();
    // T3: unordered, with an ignored address and a duplicate address
    wr(0, 4, 1); wr(1, 8, 2); wr(2, 8, 3); go(1, 3);
    st(8, 3, 1); st(12, 9, 2);
    chk("t3.match_cnt_after_ignored", 32'(bu.match_cnt), 1);
    expect_res(1, 1, 0, 0, 0, 0, 3, 4);
    st(4, 1, 3); st(8, 2, 4); tick();
    go(1, 3);
    expect_res(1, 0, 1, 1, 0, 32'h300, 0, 1);
    st(8, 5, 32'h300); tick();
    // T4: timeout after exactly 50 RUN cycles, later stores ignored
    wr(0, 20, 7); pc = 32'h400; go(0, 1); repeat (49) tick();
    chk("t4.busy_before", 32'(bo.busy), 1);
    chk("t4.cycles_before", bo.cycles, 49);
    expect_res(0, 0, 1, 2, 0, 32'h400, 0, 50);
    tick(); st(20, 7, 32'h404); tick();
    chk("t4.late_store_match_cnt", 32'(bo.match_cnt), 0);
    chk("t4.late_store_code", 32'(bo.fail_code), 2);
    chk("t4.late_store_cycles", bo.cycles, 50);
    // T5: n=0 passes on the first RUN edge, restart clears the result
    expect_res(0, 1, 0, 0, 0, 0, 0, 1);
    go(0, 0); tick(); tick();
    go(0, 1);
    chk("t5.restart_busy", 32'(bo.busy), 1);
    chk("t5.restart_pass", 32'(bo.pass), 0);
    chk("t5.restart_fail", 32'(bo.fail), 0);
    chk("t5.restart_cycles", bo.cycles, 0);
    expect_res(0, 1, 0, 0, 0, 0, 1, 1);
    st(20, 7, 32'h500); tick();
    // Full table with n_exp above DEPTH clamps to DEPTH
    for (int i = 0; i < 8; i++) wr(3'(i), 32'h1000 + 32'(4*i), 32'(3*i));
    go(0, 15);
    expect_res(0, 1, 0, 0, 0, 0, 8, 8);
    for (int i = 0; i < 8; i++) st(32'h1000 + 32'(4*i), 32'(3*i), 32'(i));
    tick();
    // T6: reset mid-RUN after one match; table write during RUN is dropped
    wr(0, 32'h30, 1); wr(1, 32'h34, 2); go(0, 2);
    st(32'h30, 1, 32'h600);
    chk("t6.match_cnt_mid", 32'(bo.match_cnt), 1);
    wr(1, 32'h34, 99);
    reset = 0; tick();
    chk_reset_vals("t6.reset");
    reset = 1; tick();
    go(0, 2);
    expect_res(0, 1, 0, 0, 0, 0, 2, 2);
    st(32'h30, 1, 32'h610); st(32'h34, 2, 32'h614);
    repeat (3) tick();
    if (q_o.size() != 0 || q_u.size() != 0) begin
      checks++; errors++;
      $display("FAIL pending_results: got %0d ord and %0d unord outstanding expected 0", q_o.size(), q_u.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
